// File: rtl/serial_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : serial_arb_pkg                                                  |
// | Brief    : Shared types and defaults for the serial transmit arbiter.      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package serial_arb_pkg;

    localparam int unsigned c_DATA_W_DEFAULT = 32;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LAUNCH    = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_IDLE = 3'd3,
        ST_DONE      = 3'd4
    } arb_state_e;

endpackage : serial_arb_pkg
`default_nettype wire

// File: rtl/serial_tx_arbiter_sync_2ff.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sync_2ff                                                        |
// | Brief    : Two-flop single-bit synchroniser, async active-high clear.      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module sync_2ff (
    input  logic Clk,
    input  logic Reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/serial_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : serial_tx_arbiter                                               |
// | Brief    : Round-robin arbiter sharing one serial transceiver; optional    |
// |            transfer timeout enabled by SERIAL_ARB_TIMEOUT_EN.              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module serial_tx_arbiter
    import serial_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = c_DATA_W_DEFAULT,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic [NUM_REQ-1:0]         ReqValid,
    input  logic [NUM_REQ*DATA_W-1:0]  ReqData,
    output logic [NUM_REQ-1:0]         ReqAck,
    output logic [NUM_REQ-1:0]         ReqDone,
    output logic [NUM_REQ-1:0]         ReqErr,
    output logic [DATA_W-1:0]          TxDataIn,
    output logic                       TxSample,
    output logic                       TxStartTx,
    input  logic                       TxBusy,
    output logic                       ArbBusy,
    output logic [$clog2(NUM_REQ)-1:0] GrantIdx
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_param_check
        $error("serial_tx_arbiter: NUM_REQ must be 2..8 and TIMEOUT >= 1");
    end

    arb_state_e          state_q;
    logic [IDX_W-1:0]    ptr_q;
    logic [IDX_W-1:0]    grant_q;
    logic [DATA_W-1:0]   data_q;
    logic [NUM_REQ-1:0]  ack_q;
    logic [NUM_REQ-1:0]  done_q;
    logic                sample_q;
    logic                start_q;
    logic                busy_s;
    logic                tmo_fire;
    logic [IDX_W-1:0]    pick_d;

    sync_2ff u_busy_sync (
        .Clk   (Clk),
        .Reset (Reset),
        .d_i   (TxBusy),
        .q_o   (busy_s)
    );

    // First valid requester strictly after the pointer, wrapping cyclically.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [NUM_REQ-1:0] req,
        input logic [IDX_W-1:0]   ptr
    );
        logic [IDX_W-1:0] pick;
        int               cand;
        pick = ptr;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = (int'(ptr) + k) % int'(NUM_REQ);
            if (req[cand]) begin
                pick = IDX_W'(cand);
            end
        end
        return pick;
    endfunction

    assign pick_d = rr_pick(ReqValid, ptr_q);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            ptr_q    <= IDX_W'(NUM_REQ - 1);
            grant_q  <= '0;
            data_q   <= '0;
            ack_q    <= '0;
            done_q   <= '0;
            sample_q <= 1'b0;
            start_q  <= 1'b0;
        end else begin
            ack_q    <= '0;
            done_q   <= '0;
            sample_q <= 1'b0;
            start_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if ((|ReqValid) && !busy_s) begin
                        grant_q        <= pick_d;
                        data_q         <= ReqData[int'(pick_d)*DATA_W +: DATA_W];
                        ack_q[pick_d]  <= 1'b1;
                        state_q        <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    sample_q <= 1'b1;
                    start_q  <= 1'b1;
                    state_q  <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (busy_s) begin
                        state_q <= ST_WAIT_IDLE;
                    end else if (tmo_fire) begin
                        ptr_q   <= grant_q;
                        state_q <= ST_IDLE;
                    end
                end
                ST_WAIT_IDLE: begin
                    if (!busy_s) begin
                        done_q[grant_q] <= 1'b1;
                        state_q         <= ST_DONE;
                    end else if (tmo_fire) begin
                        ptr_q   <= grant_q;
                        state_q <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    ptr_q   <= grant_q;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef SERIAL_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0]   tmo_cnt_q;
    logic [CNT_W-1:0]   tmo_cnt_d;
    logic [NUM_REQ-1:0] err_q;
    logic               waiting;

    assign waiting   = (state_q == ST_WAIT_BUSY) || (state_q == ST_WAIT_IDLE);
    assign tmo_cnt_d = tmo_cnt_q + 1'b1;
    // A completing handshake in the same cycle takes priority over the timeout.
    assign tmo_fire  = (tmo_cnt_d == CNT_W'(TIMEOUT)) &&
                       (((state_q == ST_WAIT_BUSY) && !busy_s) ||
                        ((state_q == ST_WAIT_IDLE) &&  busy_s));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            tmo_cnt_q <= '0;
            err_q     <= '0;
        end else begin
            err_q <= '0;
            if (state_q == ST_LAUNCH) begin
                tmo_cnt_q <= '0;
            end else if (waiting) begin
                tmo_cnt_q <= tmo_cnt_d;
            end
            if (tmo_fire) begin
                err_q[grant_q] <= 1'b1;
            end
        end
    end

    assign ReqErr = err_q;
`else
    assign tmo_fire = 1'b0;
    assign ReqErr   = '0;
`endif

    assign ReqAck    = ack_q;
    assign ReqDone   = done_q;
    assign TxDataIn  = data_q;
    assign TxSample  = sample_q;
    assign TxStartTx = start_q;
    assign GrantIdx  = grant_q;
    assign ArbBusy   = (state_q != ST_IDLE);

endmodule : serial_tx_arbiter
`default_nettype wire

// File: tb/tb_serial_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_serial_tx_arbiter                                            |
// | Brief    : Self-checking bench: reference model plus directed scenarios.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_serial_tx_arbiter;

    localparam int N   = 4;
    localparam int W   = 32;
    localparam int TMO = 64;
`ifdef SERIAL_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic           Clk = 1'b0;
    logic           Reset = 1'b1;
    logic [N-1:0]   ReqValid = '0;
    logic [N*W-1:0] ReqData = '0;
    logic [N-1:0]   ReqAck, ReqDone, ReqErr;
    logic [W-1:0]   TxDataIn;
    logic           TxSample, TxStartTx, ArbBusy;
    logic           TxBusy;
    logic [1:0]     GrantIdx;

    int checks = 0;
    int errors = 0;

    serial_tx_arbiter #(.NUM_REQ(N), .DATA_W(W), .TIMEOUT(TMO)) dut (
        .Clk(Clk), .Reset(Reset), .ReqValid(ReqValid), .ReqData(ReqData),
        .ReqAck(ReqAck), .ReqDone(ReqDone), .ReqErr(ReqErr),
        .TxDataIn(TxDataIn), .TxSample(TxSample), .TxStartTx(TxStartTx),
        .TxBusy(TxBusy), .ArbBusy(ArbBusy), .GrantIdx(GrantIdx)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transceiver: busy rises a few cycles after StartTx and stays up busy_len cycles.
    int busy_len = 6;
    bit tx_stuck = 1'b0;
    int tx_st, tx_cnt;
    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            TxBusy <= 1'b0; tx_st <= 0; tx_cnt <= 0;
        end else begin
            case (tx_st)
                0: if (TxStartTx && !tx_stuck) begin tx_st <= 1; tx_cnt <= 2; end
                1: if (tx_cnt <= 1) begin TxBusy <= 1'b1; tx_st <= 2; tx_cnt <= busy_len; end
                   else tx_cnt <= tx_cnt - 1;
                default: if (tx_cnt <= 1) begin TxBusy <= 1'b0; tx_st <= 0; end
                         else tx_cnt <= tx_cnt - 1;
            endcase
        end
    end

    // Reference model: phase of the current transfer and the RR pointer.
    function automatic int rr_next(input logic [N-1:0] v, input int p);
        for (int k = 1; k <= N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return 0;
    endfunction

    logic [1:0]   bs_pipe;
    int           phase, age, m_ptr, m_grant;
    logic [W-1:0] m_data;
    logic [N-1:0] m_ack, m_done, m_err;
    logic         m_start;

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            bs_pipe <= '0; phase <= 0; age <= 0; m_ptr <= N - 1; m_grant <= 0;
            m_data <= '0; m_ack <= '0; m_done <= '0; m_err <= '0; m_start <= 1'b0;
        end else begin
            bs_pipe <= {bs_pipe[0], TxBusy};
            m_ack <= '0; m_done <= '0; m_err <= '0; m_start <= 1'b0;
            if (phase == 0) begin
                if (ReqValid != '0 && !bs_pipe[1]) begin
                    m_grant <= rr_next(ReqValid, m_ptr);
                    m_data  <= ReqData[rr_next(ReqValid, m_ptr)*W +: W];
                    m_ack   <= N'(1) << rr_next(ReqValid, m_ptr);
                    phase   <= 1;
                end
            end else if (phase == 1) begin
                m_start <= 1'b1; age <= 0; phase <= 2;
            end else if (phase == 2 || phase == 3) begin
                age <= age + 1;
                if (phase == 2 && bs_pipe[1]) phase <= 3;
                else if (phase == 3 && !bs_pipe[1]) begin
                    m_done <= N'(1) << m_grant; phase <= 4;
                end else if (TMO_EN && age + 1 == TMO) begin
                    m_err <= N'(1) << m_grant; m_ptr <= m_grant; phase <= 0;
                end
            end else begin
                m_ptr <= m_grant; phase <= 0;
            end
        end
    end

    always @(negedge Clk) begin
        check("ack",    32'(ReqAck),    32'(m_ack));
        check("done",   32'(ReqDone),   32'(m_done));
        check("err",    32'(ReqErr),    32'(m_err));
        check("sample", 32'(TxSample),  32'(m_start));
        check("start",  32'(TxStartTx), 32'(m_start));
        check("busy",   32'(ArbBusy),   32'(phase != 0));
        check("grant",  32'(GrantIdx),  32'(m_grant));
        check("data",   TxDataIn,       m_data);
    end

    function automatic int onehot_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic wait_ack(input string name, output int idx);
        idx = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge Clk);
            if (ReqAck != '0) begin idx = onehot_idx(ReqAck); return; end
        end
        errors++;
        $display("FAIL %s: no ReqAck within 300 cycles (got none, required one)", name);
    endtask

    task automatic wait_done(input string name, output int idx);
        idx = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge Clk);
            if (ReqDone != '0) begin idx = onehot_idx(ReqDone); return; end
        end
        errors++;
        $display("FAIL %s: no ReqDone within 300 cycles (got none, required one)", name);
    endtask

    task automatic do_reset();
        @(negedge Clk); Reset = 1'b1;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
    endtask

    initial begin : stim
        int idx, n;
        int exp_order[5];
        exp_order = '{0, 1, 2, 3, 0};
        for (int i = 0; i < N; i++) ReqData[i*W +: W] = 32'hD000_0000 + 32'(i);

        repeat (2) @(negedge Clk);
        check("rst_ack",   32'(ReqAck),   0);
        check("rst_start", 32'(TxStartTx), 0);
        check("rst_busy",  32'(ArbBusy),  0);
        check("rst_grant", 32'(GrantIdx), 0);
        check("rst_data",  TxDataIn,      0);
        Reset = 1'b0;

        // 1: single request
        ReqData[0 +: W] = 32'hA5A5_0001;
        ReqValid = 4'b0001;
        wait_ack("t1_ack", idx);
        check("t1_ack", 32'(ReqAck), 32'h1);
        ReqValid = 4'b0000;
        @(negedge Clk);
        check("t1_start", 32'({TxSample, TxStartTx}), 32'h3);
        check("t1_data", TxDataIn, 32'hA5A5_0001);
        wait_done("t1_done", idx);
        check("t1_done", 32'(ReqDone), 32'h1);

        // 2: all requesting, strict round robin from reset
        do_reset();
        ReqValid = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            wait_ack("t2_ack", idx);
            check("t2_order", 32'(idx), 32'(exp_order[t]));
            wait_done("t2_done", n);
            check("t2_done_idx", 32'(n), 32'(exp_order[t]));
        end
        ReqValid = 4'b0000;
        repeat (4) @(negedge Clk);

        // 3: pointer wrap 3 -> 0 -> 3
        ReqValid = 4'b1000;
        wait_ack("t3_ack3", idx);
        check("t3_first", 32'(idx), 32'd3);
        ReqValid = 4'b1001;
        wait_ack("t3_ack0", idx);
        check("t3_wrap", 32'(idx), 32'd0);
        ReqValid = 4'b1000;
        wait_ack("t3_ack3b", idx);
        check("t3_again", 32'(idx), 32'd3);
        ReqValid = 4'b0000;
        wait_done("t3_done", idx);

        // 4: requester drops the cycle after its ack
        ReqValid = 4'b0010;
        wait_ack("t4_ack", idx);
        check("t4_ack", 32'(idx), 32'd1);
        @(negedge Clk);
        ReqValid = 4'b0000;
        wait_done("t4_done", idx);
        check("t4_done", 32'(ReqDone), 32'h2);

        // 5: reset while waiting for busy to fall
        busy_len = 12;
        ReqValid = 4'b0100;
        wait_ack("t5_ack", idx);
        ReqValid = 4'b0000;
        n = 0;
        while (!TxBusy && n < 50) begin @(negedge Clk); n++; end
        check("t5_busy_seen", 32'(TxBusy), 32'h1);
        repeat (4) @(negedge Clk);
        check("t5_in_xfer", 32'(ArbBusy), 32'h1);
        #2 Reset = 1'b1;
        #1;
        check("t5_rst_outs", 32'({ReqAck, ReqDone, ReqErr, TxSample, TxStartTx, ArbBusy, GrantIdx}), 0);
        check("t5_rst_data", TxDataIn, 0);
        @(negedge Clk);
        Reset = 1'b0;
        busy_len = 6;
        ReqValid = 4'b1111;
        wait_ack("t5_ack2", idx);
        check("t5_first_grant", 32'(idx), 32'd0);
        ReqValid = 4'b0000;
        wait_done("t5_done", idx);

`ifdef SERIAL_ARB_TIMEOUT_EN
        // 6: transceiver never goes busy
        repeat (3) @(negedge Clk);
        tx_stuck = 1'b1;
        ReqValid = 4'b0100;
        wait_ack("t6_ack", idx);
        ReqValid = 4'b0000;
        @(negedge Clk);
        check("t6_start", 32'(TxStartTx), 32'h1);
        n = 0;
        while (ReqErr == '0 && n < 200) begin
            @(negedge Clk); n++;
            check("t6_no_done", 32'(ReqDone), 0);
        end
        check("t6_err_lat", 32'(n), 32'd64);
        check("t6_err_vec", 32'(ReqErr), 32'h4);
        check("t6_busy_off", 32'(ArbBusy), 32'h0);
        tx_stuck = 1'b0;
        repeat (3) @(negedge Clk);
`endif

        repeat (3) @(negedge Clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_serial_tx_arbiter
`default_nettype wire
